// File: rtl/hpm_ovf_ctrl_pkg.sv
// Shared types and CSR addresses for the HPM overflow / privilege-filter controller.
package hpm_ovf_ctrl_pkg;

    localparam int unsigned XLEN_DEFAULT = 64;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_t;

    typedef struct packed {
        logic of;
        logic minh;
        logic sinh;
        logic uinh;
    } hpm_filter_t;

    typedef enum logic {
        LCOF_IDLE,
        LCOF_PENDING
    } lcof_state_e;

    localparam logic [11:0] CSR_MHPM_EVENT_3  = 12'h323;
    localparam logic [11:0] CSR_MHPM_EVENT_3H = 12'h723;
    localparam logic [11:0] CSR_SCOUNTOVF     = 12'hDA0;

endpackage

// File: rtl/hpm_filter_slice.sv
// One counter's {OF,MINH,SINH,UINH} filter register, privilege gating and wrap detect.
// Build option HPM_OVF_FREEZE_EN: an overflowed counter stops counting until OF is cleared.
module hpm_filter_slice
    import hpm_ovf_ctrl_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  priv_lvl_t    priv_lvl_i,
    input  logic         debug_mode_i,
    input  logic         event_i,
    input  logic [63:0]  counter_val_i,
    input  logic         wr_en_i,
    input  hpm_filter_t  wr_filter_i,
    output hpm_filter_t  filter_o,
    output logic         count_en_o,
    output logic         of_rise_o
);

    hpm_filter_t filter_q, filter_d;
    logic        inh;
    logic        ovf;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        inh        = 1'b0;
        count_en_o = 1'b0;
        ovf        = 1'b0;
        filter_d   = filter_q;
        of_rise_o  = 1'b0;

        case (priv_lvl_i)
            PRIV_LVL_M: inh = filter_q.minh;
            PRIV_LVL_S: inh = filter_q.sinh;
            PRIV_LVL_U: inh = filter_q.uinh;
            default:    inh = 1'b0;
        endcase

`ifdef HPM_OVF_FREEZE_EN
        count_en_o = event_i & ~debug_mode_i & ~inh & ~filter_q.of;
`else
        count_en_o = event_i & ~debug_mode_i & ~inh;
`endif

        ovf = count_en_o & (counter_val_i == 64'hFFFF_FFFF_FFFF_FFFF);

        // Hardware overflow wins over a simultaneous software write of OF.
        if (wr_en_i) filter_d = wr_filter_i;
        if (ovf)     filter_d.of = 1'b1;

        of_rise_o = filter_d.of & ~filter_q.of;
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) filter_q <= '0;
        else         filter_q <= filter_d;
    end

    assign filter_o = filter_q;

endmodule

// File: rtl/hpm_ovf_ctrl.sv
// HPM overflow controller: per-counter filter slices, CSR decode, scountovf and LCOFI pending FSM.
// Build option HPM_OVF_FREEZE_EN (see hpm_filter_slice) freezes wrapped counters.
module hpm_ovf_ctrl
    import hpm_ovf_ctrl_pkg::*;
#(
    parameter int unsigned NumCounters = 6,
    parameter int unsigned XLEN        = XLEN_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  priv_lvl_t                    priv_lvl_i,
    input  logic                         debug_mode_i,
    input  logic [NumCounters-1:0]       event_i,
    input  logic [NumCounters-1:0][63:0] counter_val_i,
    output logic [NumCounters-1:0]       count_en_o,
    input  logic [11:0]                  addr_i,
    input  logic                         we_i,
    input  logic [XLEN-1:0]              data_i,
    output logic [XLEN-1:0]              data_o,
    output logic                         hit_o,
    output logic                         lcof_irq_o,
    input  logic                         lcof_clr_i
);

    hpm_filter_t            filter [NumCounters];
    logic [NumCounters-1:0] wr_en;
    logic [NumCounters-1:0] of_rise;
    hpm_filter_t            wr_filter;
    lcof_state_e            state_q, state_d;
    logic                   unused_data;

    // The filter nibble is the top four bits in both mhpmevent (RV64) and mhpmeventh (RV32).
    assign wr_filter   = hpm_filter_t'(data_i[XLEN-1 -: 4]);
    assign unused_data = ^data_i[XLEN-5:0];

    for (genvar i = 0; i < NumCounters; i++) begin : g_slice
        hpm_filter_slice u_slice (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .priv_lvl_i   (priv_lvl_i),
            .debug_mode_i (debug_mode_i),
            .event_i      (event_i[i]),
            .counter_val_i(counter_val_i[i]),
            .wr_en_i      (wr_en[i]),
            .wr_filter_i  (wr_filter),
            .filter_o     (filter[i]),
            .count_en_o   (count_en_o[i]),
            .of_rise_o    (of_rise[i])
        );
    end

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        wr_en  = '0;

        if (addr_i == CSR_SCOUNTOVF) begin
            hit_o = 1'b1;
            for (int i = 0; i < NumCounters; i++) data_o[i+3] = filter[i].of;
        end

        for (int i = 0; i < NumCounters; i++) begin
            // On RV32 the low mhpmevent half is still ours but carries no filter bits.
            if (addr_i == CSR_MHPM_EVENT_3 + 12'(i)) hit_o = 1'b1;
            if ((XLEN == 64 && addr_i == CSR_MHPM_EVENT_3  + 12'(i)) ||
                (XLEN != 64 && addr_i == CSR_MHPM_EVENT_3H + 12'(i))) begin
                hit_o                = 1'b1;
                data_o[XLEN-1 -: 4]  = filter[i];
                wr_en[i]             = we_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LCOF_IDLE:    if (|of_rise) state_d = LCOF_PENDING;
            LCOF_PENDING: if (lcof_clr_i && !(|of_rise)) state_d = LCOF_IDLE;
            default:      state_d = LCOF_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= LCOF_IDLE;
        else         state_q <= state_d;
    end

    assign lcof_irq_o = (state_q == LCOF_PENDING);

endmodule
